// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter that shares one SPI master between two requesters.
// It stretches the start pulse, detects the done edge and aborts stuck transactions.
module spi_req_arbiter #(
  parameter int START_HOLD = 3,
  parameter int TIMEOUT    = 1024,
  parameter int TW         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       we0,
  input  logic [7:0] addr0,
  input  logic [7:0] wdata0,
  output logic       ack0,
  output logic       err0,
  output logic [7:0] rdata0,
  input  logic       req1,
  input  logic       we1,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata1,
  output logic       ack1,
  output logic       err1,
  output logic [7:0] rdata1,
  output logic       m_start_w,
  output logic       m_start_r,
  output logic [7:0] m_addr,
  output logic [7:0] m_wdata,
  input  logic [7:0] m_rdata,
  input  logic       m_done,
  output logic       busy,
  output logic       owner
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_START,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [TW-1:0] HOLD_LAST = TW'(START_HOLD - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] CNT_MAX   = '1;

  state_t        state_reg, state_next;
  logic          last_reg;
  logic          owner_reg;
  logic          we_reg;
  logic [7:0]    addr_reg;
  logic [7:0]    wdata_reg;
  logic [TW-1:0] cnt_reg;
  logic          m_done_d_reg;

  logic          any_req;
  logic          grant_idx;
  logic          done_edge;
  logic          hold_last;
  logic          timeout_hit;
  logic          resp_load;
  logic [1:0]    ack_vec;

  assign any_req     = req0 | req1;
  // A lone requester wins outright; a tie goes to the port not served last.
  assign grant_idx   = (req0 & req1) ? ~last_reg : req1;
  assign done_edge   = m_done & ~m_done_d_reg;
  assign hold_last   = (cnt_reg == HOLD_LAST);
  assign timeout_hit = (cnt_reg >= TO_LAST);
  assign resp_load   = (state_reg == S_WAIT) & (done_edge | timeout_hit);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    m_start_w  = 1'b0;
    m_start_r  = 1'b0;
    ack_vec    = 2'b00;
    case (state_reg)
      S_IDLE: begin
        if (any_req) state_next = S_GRANT;
      end
      S_GRANT: begin
        busy       = 1'b1;
        state_next = S_START;
      end
      S_START: begin
        busy      = 1'b1;
        m_start_w = we_reg;
        m_start_r = ~we_reg;
        if (hold_last) state_next = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (done_edge || timeout_hit) state_next = S_RESP;
      end
      S_RESP: begin
        busy               = 1'b1;
        ack_vec[owner_reg] = 1'b1;
        state_next         = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Command is captured once per grant; requester inputs are ignored until IDLE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_reg  <= 1'b1;
      owner_reg <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= 8'h00;
      wdata_reg <= 8'h00;
    end else if (state_reg == S_IDLE && any_req) begin
      last_reg  <= grant_idx;
      owner_reg <= grant_idx;
      we_reg    <= grant_idx ? we1 : we0;
      addr_reg  <= grant_idx ? addr1 : addr0;
      wdata_reg <= grant_idx ? wdata1 : wdata0;
    end
  end

  // One counter times both the start hold and the watchdog; it saturates.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (state_reg == S_GRANT) begin
      cnt_reg <= '0;
    end else if ((state_reg == S_START || state_reg == S_WAIT) && cnt_reg != CNT_MAX) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      m_done_d_reg <= 1'b0;
    end else begin
      m_done_d_reg <= m_done;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      logic [7:0] rdata_reg;
      logic       err_reg;
      // A watchdog exit is the only way into RESP without a done edge.
      always_ff @(posedge clk) begin
        if (!rst) begin
          rdata_reg <= 8'h00;
          err_reg   <= 1'b0;
        end else if (resp_load && (int'(owner_reg) == gi)) begin
          err_reg   <= ~done_edge;
          rdata_reg <= (done_edge && !we_reg) ? m_rdata : 8'h00;
        end
      end
    end
  endgenerate

  assign ack0    = ack_vec[0];
  assign ack1    = ack_vec[1];
  assign err0    = g_port[0].err_reg;
  assign err1    = g_port[1].err_reg;
  assign rdata0  = g_port[0].rdata_reg;
  assign rdata1  = g_port[1].rdata_reg;
  assign m_addr  = addr_reg;
  assign m_wdata = wdata_reg;
  assign owner   = owner_reg;

endmodule
